// File: rtl/zorro_intc_multi.sv
// rtl/zorro_intc_multi.sv - multi-channel Zorro III interrupt controller with quick-int vector delivery
//
// Collects N_CH active-low device interrupt lines and, per channel, keeps an
// 8-bit vector, a valid bit, an enable bit and a level/edge mode bit.
// Register window accesses and quick-interrupt poll/vector cycles are handled
// by one bus FSM. Only one action is taken per bus cycle.
//
// Optional feature macro: ZINTC_ROUND_ROBIN_EN
//   defined   - winner search starts after the last acknowledged channel
//   undefined - fixed priority, lowest channel index wins
//
// Ports:
//   clk            system clock
//   IORST          synchronous active-high reset
//   intreg_cycle   decoded register window access
//   reg_addr       register select (vectors, enable, mode, pending status)
//   quickint_cycle decoded quick-interrupt acknowledge cycle
//   FCS_n          full cycle strobe, low while a bus cycle is active
//   DOE            data output enable phase
//   DS0_n          data strobe, active low
//   READ           1 = bus read
//   SLAVE_n        bus SLAVE line, active low
//   set_reset      new valid bit written along with a vector
//   din            write data
//   SINT_n         device interrupt requests, active low
//   dout           registered read / vector data
//   dtack          cycle acknowledge
//   slave          quick-int slave claim
//   vector_read    vector or register read in progress
//   int_sig        interrupt request to the bus driver
//   ack_ch         one-hot pulse naming the channel whose vector was delivered

module zorro_intc_multi #(
  parameter int         N_CH           = 4,
  parameter logic [7:0] DEFAULT_VECTOR = 8'd26,
  parameter int         RA_W           = $clog2(N_CH) + 2
) (
  input  logic            clk,
  input  logic            IORST,
  input  logic            intreg_cycle,
  input  logic [RA_W-1:0] reg_addr,
  input  logic            quickint_cycle,
  input  logic            FCS_n,
  input  logic            DOE,
  input  logic            DS0_n,
  input  logic            READ,
  input  logic            SLAVE_n,
  input  logic            set_reset,
  input  logic [7:0]      din,
  input  logic [N_CH-1:0] SINT_n,
  output logic [7:0]      dout,
  output logic            dtack,
  output logic            slave,
  output logic            vector_read,
  output logic            int_sig,
  output logic [N_CH-1:0] ack_ch
);

  localparam int IW = (N_CH > 1) ? $clog2(N_CH) : 1;

  typedef enum logic [2:0] {IDLE, REG_ACK, QI_SLAVE, QI_ACK, WAIT_END} state_t;

  state_t          state;
  logic [7:0]      vector [N_CH];
  logic [N_CH-1:0] valid;
  logic [N_CH-1:0] enable;
  logic [N_CH-1:0] mode;
  logic [N_CH-1:0] pend_edge;
  logic [N_CH-1:0] raw_q;
  logic [N_CH-1:0] raw_d;
  logic            armed;
  logic [IW-1:0]   win_q;
`ifdef ZINTC_ROUND_ROBIN_EN
  logic [IW-1:0]   last_ack;
`endif

  logic [N_CH-1:0] raw_comb;
  logic [N_CH-1:0] rise;
  logic [N_CH-1:0] pending;
  logic [N_CH-1:0] elig;
  logic [N_CH-1:0] win_oh;
  logic [N_CH-1:0] w1c_mask;
  logic [N_CH-1:0] ack_mask;
  logic [N_CH-1:0] pend_edge_nxt;
  logic [IW-1:0]   win_idx;
  logic [IW-1:0]   cand_idx;
  logic            found;
  logic [7:0]      rd_data;
  logic            reg_go;
  logic            qi_go;
  logic            ack_go;
  int              addr_i;

  function automatic logic [7:0] widen(input logic [N_CH-1:0] v);
    logic [7:0] t;
    t = '0;
    t[N_CH-1:0] = v;
    return t;
  endfunction

  assign raw_comb = ~SINT_n;
  // raw_d follows raw_q every clk, so an edge latched on the last FCS_n-high
  // clk is still seen one clk later, possibly inside a bus cycle.
  assign rise     = raw_q & ~raw_d;
  assign pending  = (mode & pend_edge) | (~mode & raw_q);
  assign elig     = pending & enable & valid;
  // Unassigned channels bypass the synchroniser so autovector sources still work.
  assign int_sig  = |(enable & ((valid & pending) | (~valid & raw_comb)));
  assign addr_i   = int'(reg_addr);

  assign reg_go = (state == IDLE) && armed && !FCS_n && intreg_cycle && DOE && (READ || !DS0_n);
  assign qi_go  = (state == IDLE) && armed && !FCS_n && quickint_cycle && (|elig) && !DOE && DS0_n;
  assign ack_go = (state == QI_SLAVE) && !FCS_n && DOE && !DS0_n && !SLAVE_n;

  always_comb begin
    win_idx  = '0;
    cand_idx = '0;
    found    = 1'b0;
    for (int k = 0; k < N_CH; k++) begin
`ifdef ZINTC_ROUND_ROBIN_EN
      cand_idx = IW'((int'(last_ack) + 1 + k) % N_CH);
`else
      cand_idx = IW'(k);
`endif
      if (!found && elig[cand_idx]) begin
        found   = 1'b1;
        win_idx = cand_idx;
      end
    end
  end

  always_comb begin
    win_oh = '0;
    for (int i = 0; i < N_CH; i++) begin
      win_oh[i] = (win_q == IW'(i));
    end
  end

  always_comb begin
    rd_data = '0;
    if (addr_i < N_CH)           rd_data = vector[reg_addr[IW-1:0]];
    else if (addr_i == N_CH)     rd_data = widen(enable);
    else if (addr_i == N_CH + 1) rd_data = widen(mode);
    else if (addr_i == N_CH + 2) rd_data = widen(pending);
  end

  assign w1c_mask = (reg_go && !READ && addr_i == N_CH + 2) ? din[N_CH-1:0] : '0;
  assign ack_mask = ack_go ? win_oh : '0;
  // Set after clear: a new edge on the clearing clk survives.
  assign pend_edge_nxt = ((pend_edge & ~(w1c_mask | ack_mask)) | rise) & mode;

  always_ff @(posedge clk) begin
    if (IORST) begin
      state       <= IDLE;
      for (int i = 0; i < N_CH; i++) vector[i] <= DEFAULT_VECTOR;
      valid       <= '0;
      enable      <= '1;
      mode        <= '0;
      pend_edge   <= '0;
      raw_q       <= '0;
      raw_d       <= '0;
      armed       <= 1'b0;
      win_q       <= '0;
`ifdef ZINTC_ROUND_ROBIN_EN
      last_ack    <= IW'(N_CH - 1);
`endif
      dout        <= DEFAULT_VECTOR;
      dtack       <= 1'b0;
      slave       <= 1'b0;
      vector_read <= 1'b0;
      ack_ch      <= '0;
    end else begin
      raw_d     <= raw_q;
      pend_edge <= pend_edge_nxt;
      ack_ch    <= '0;
      if (FCS_n) begin
        raw_q       <= raw_comb;
        armed       <= 1'b1;
        state       <= IDLE;
        dtack       <= 1'b0;
        slave       <= 1'b0;
        vector_read <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (reg_go) begin
              state <= REG_ACK;
              if (READ) begin
                dout        <= rd_data;
                vector_read <= 1'b1;
              end else if (addr_i < N_CH) begin
                vector[reg_addr[IW-1:0]] <= din;
                valid[reg_addr[IW-1:0]]  <= set_reset;
              end else if (addr_i == N_CH) begin
                enable <= din[N_CH-1:0];
              end else if (addr_i == N_CH + 1) begin
                mode <= din[N_CH-1:0];
              end
            end else if (qi_go) begin
              state <= QI_SLAVE;
              slave <= 1'b1;
              win_q <= win_idx;
            end
          end
          REG_ACK: begin
            dtack <= 1'b1;
            state <= WAIT_END;
          end
          QI_SLAVE: begin
            if (ack_go) begin
              dout        <= vector[win_q];
              dtack       <= 1'b1;
              vector_read <= 1'b1;
              ack_ch      <= win_oh;
`ifdef ZINTC_ROUND_ROBIN_EN
              last_ack    <= win_q;
`endif
              state       <= QI_ACK;
            end
          end
          QI_ACK:   state <= WAIT_END;
          WAIT_END: state <= WAIT_END;
          default:  state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_zorro_intc_multi.sv
// tb/tb_zorro_intc_multi.sv - directed self-checking bench for zorro_intc_multi
module tb_zorro_intc_multi;
  logic       clk = 1'b0;
  logic       IORST;
  logic       intreg_cycle;
  logic [3:0] reg_addr;
  logic       quickint_cycle;
  logic       FCS_n;
  logic       DOE;
  logic       DS0_n;
  logic       READ;
  logic       SLAVE_n;
  logic       set_reset;
  logic [7:0] din;
  logic [3:0] SINT_n;
  logic [7:0] dout;
  logic       dtack;
  logic       slave;
  logic       vector_read;
  logic       int_sig;
  logic [3:0] ack_ch;

  int vectors = 0;
  int miscompares = 0;

  logic       q_slave, q_dtack, q_ack_after, q_clear;
  logic [7:0] q_dout, r_data;
  logic [3:0] q_ack;
  logic       r_dtack;

  zorro_intc_multi #(.N_CH(4), .DEFAULT_VECTOR(8'd26)) dut (
    .clk(clk), .IORST(IORST), .intreg_cycle(intreg_cycle), .reg_addr(reg_addr),
    .quickint_cycle(quickint_cycle), .FCS_n(FCS_n), .DOE(DOE), .DS0_n(DS0_n),
    .READ(READ), .SLAVE_n(SLAVE_n), .set_reset(set_reset), .din(din),
    .SINT_n(SINT_n), .dout(dout), .dtack(dtack), .slave(slave),
    .vector_read(vector_read), .int_sig(int_sig), .ack_ch(ack_ch)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic bus_idle();
    FCS_n = 1'b1; intreg_cycle = 1'b0; quickint_cycle = 1'b0; DOE = 1'b0;
    DS0_n = 1'b1; READ = 1'b0; SLAVE_n = 1'b1; set_reset = 1'b0; din = 8'h00;
  endtask

  task automatic reg_write(input logic [3:0] a, input logic [7:0] d, input logic sr);
    FCS_n = 1'b0; intreg_cycle = 1'b1; reg_addr = a; READ = 1'b0; DOE = 1'b1;
    DS0_n = 1'b0; din = d; set_reset = sr;
    tick(); tick();
    bus_idle();
    tick();
  endtask

  task automatic reg_read(input logic [3:0] a, output logic [7:0] d, output logic dt);
    FCS_n = 1'b0; intreg_cycle = 1'b1; reg_addr = a; READ = 1'b1; DOE = 1'b1; DS0_n = 1'b0;
    tick(); tick();
    d = dout; dt = dtack;
    bus_idle();
    tick();
  endtask

  task automatic qi_cycle(output logic s_slave, output logic [7:0] s_dout, output logic s_dtack,
                          output logic [3:0] s_ack, output logic s_ack_after, output logic s_clear);
    FCS_n = 1'b0; quickint_cycle = 1'b1; DOE = 1'b0; DS0_n = 1'b1;
    tick();
    s_slave = slave;
    DOE = 1'b1; DS0_n = 1'b0; SLAVE_n = !slave;
    tick();
    s_dout = dout; s_dtack = dtack; s_ack = ack_ch;
    tick();
    s_ack_after = |ack_ch;
    bus_idle();
    tick();
    s_clear = dtack | slave | vector_read;
  endtask

  task automatic test_reset();
    IORST = 1'b1; SINT_n = 4'hF; reg_addr = 4'h0; bus_idle();
    tick(); tick();
    IORST = 1'b0;
    vectors++; if (dout !== 8'd26) begin miscompares++; $display("FAIL reset_dout: got %0d expected 26", dout); end
    vectors++; if ({dtack, slave, vector_read} !== 3'b000) begin miscompares++; $display("FAIL reset_flags: got %b expected 000", {dtack, slave, vector_read}); end
    vectors++; if (ack_ch !== 4'b0000) begin miscompares++; $display("FAIL reset_ack: got %b expected 0000", ack_ch); end
    vectors++; if (int_sig !== 1'b0) begin miscompares++; $display("FAIL reset_int: got %b expected 0", int_sig); end
    tick();
  endtask

  task automatic test_passthrough();
    SINT_n = 4'b1110;
    #1;
    vectors++; if (int_sig !== 1'b1) begin miscompares++; $display("FAIL passthru_int: got %b expected 1", int_sig); end
    tick(); tick();
    qi_cycle(q_slave, q_dout, q_dtack, q_ack, q_ack_after, q_clear);
    vectors++; if (q_slave !== 1'b0) begin miscompares++; $display("FAIL passthru_noclaim: got %b expected 0", q_slave); end
    vectors++; if (q_dtack !== 1'b0) begin miscompares++; $display("FAIL passthru_nodtack: got %b expected 0", q_dtack); end
    SINT_n = 4'hF;
    tick();
  endtask

  task automatic test_vector_delivery();
    reg_write(4'd2, 8'h40, 1'b1);
    SINT_n = 4'b1011;
    tick(); tick();
    qi_cycle(q_slave, q_dout, q_dtack, q_ack, q_ack_after, q_clear);
    vectors++; if (q_slave !== 1'b1) begin miscompares++; $display("FAIL vec_slave: got %b expected 1", q_slave); end
    vectors++; if (q_dout !== 8'h40) begin miscompares++; $display("FAIL vec_dout: got %h expected 40", q_dout); end
    vectors++; if (q_dtack !== 1'b1) begin miscompares++; $display("FAIL vec_dtack: got %b expected 1", q_dtack); end
    vectors++; if (q_ack !== 4'b0100) begin miscompares++; $display("FAIL vec_ack: got %b expected 0100", q_ack); end
    vectors++; if (q_ack_after !== 1'b0) begin miscompares++; $display("FAIL vec_ack_pulse: got %b expected 0", q_ack_after); end
    vectors++; if (q_clear !== 1'b0) begin miscompares++; $display("FAIL vec_clear: got %b expected 0", q_clear); end
    vectors++; if (dout !== 8'h40) begin miscompares++; $display("FAIL vec_dout_hold: got %h expected 40", dout); end
    reg_read(4'd2, r_data, r_dtack);
    vectors++; if (r_data !== 8'h40) begin miscompares++; $display("FAIL vec_regread: got %h expected 40", r_data); end
    vectors++; if (r_dtack !== 1'b1) begin miscompares++; $display("FAIL vec_reg_dtack: got %b expected 1", r_dtack); end
    SINT_n = 4'hF;
    reg_write(4'd2, 8'h40, 1'b0);
  endtask

  task automatic test_priority();
    logic [7:0] exp2;
    logic [3:0] exp2_ack;
`ifdef ZINTC_ROUND_ROBIN_EN
    exp2 = 8'h43; exp2_ack = 4'b1000;
`else
    exp2 = 8'h41; exp2_ack = 4'b0010;
`endif
    reg_write(4'd1, 8'h41, 1'b1);
    reg_write(4'd3, 8'h43, 1'b1);
    SINT_n = 4'b0101;
    tick(); tick();
    qi_cycle(q_slave, q_dout, q_dtack, q_ack, q_ack_after, q_clear);
    vectors++; if (q_dout !== 8'h41) begin miscompares++; $display("FAIL prio_first: got %h expected 41", q_dout); end
    vectors++; if (q_ack !== 4'b0010) begin miscompares++; $display("FAIL prio_first_ack: got %b expected 0010", q_ack); end
    qi_cycle(q_slave, q_dout, q_dtack, q_ack, q_ack_after, q_clear);
    vectors++; if (q_dout !== exp2) begin miscompares++; $display("FAIL prio_second: got %h expected %h", q_dout, exp2); end
    vectors++; if (q_ack !== exp2_ack) begin miscompares++; $display("FAIL prio_second_ack: got %b expected %b", q_ack, exp2_ack); end
    SINT_n = 4'hF;
    reg_write(4'd1, 8'h41, 1'b0);
    reg_write(4'd3, 8'h43, 1'b0);
  endtask

  task automatic pulse_ch0();
    SINT_n = 4'b1110;
    tick(); tick(); tick();
    SINT_n = 4'hF;
    tick(); tick(); tick();
  endtask

  task automatic test_edge_mode();
    reg_write(4'd5, 8'h01, 1'b0);
    reg_write(4'd0, 8'h50, 1'b1);
    pulse_ch0();
    reg_read(4'd6, r_data, r_dtack);
    vectors++; if (r_data !== 8'h01) begin miscompares++; $display("FAIL edge_status: got %h expected 01", r_data); end
    vectors++; if (int_sig !== 1'b1) begin miscompares++; $display("FAIL edge_int: got %b expected 1", int_sig); end
    qi_cycle(q_slave, q_dout, q_dtack, q_ack, q_ack_after, q_clear);
    vectors++; if (q_dout !== 8'h50) begin miscompares++; $display("FAIL edge_vec: got %h expected 50", q_dout); end
    vectors++; if (q_ack !== 4'b0001) begin miscompares++; $display("FAIL edge_ack: got %b expected 0001", q_ack); end
    reg_read(4'd6, r_data, r_dtack);
    vectors++; if (r_data !== 8'h00) begin miscompares++; $display("FAIL edge_ack_clears: got %h expected 00", r_data); end
    vectors++; if (int_sig !== 1'b0) begin miscompares++; $display("FAIL edge_int_clear: got %b expected 0", int_sig); end
  endtask

  task automatic test_w1c_collision();
    SINT_n = 4'b1110;
    tick();
    FCS_n = 1'b0; intreg_cycle = 1'b1; reg_addr = 4'd6; READ = 1'b0; DOE = 1'b1; DS0_n = 1'b0; din = 8'h01;
    tick(); tick();
    bus_idle();
    tick();
    SINT_n = 4'hF;
    tick(); tick();
    reg_read(4'd6, r_data, r_dtack);
    vectors++; if (r_data !== 8'h01) begin miscompares++; $display("FAIL w1c_set_wins: got %h expected 01", r_data); end
    reg_write(4'd6, 8'h01, 1'b0);
    reg_read(4'd6, r_data, r_dtack);
    vectors++; if (r_data !== 8'h00) begin miscompares++; $display("FAIL w1c_clear: got %h expected 00", r_data); end
  endtask

  task automatic test_enable_mask();
    pulse_ch0();
    reg_write(4'd4, 8'h00, 1'b0);
    vectors++; if (int_sig !== 1'b0) begin miscompares++; $display("FAIL mask_int: got %b expected 0", int_sig); end
    qi_cycle(q_slave, q_dout, q_dtack, q_ack, q_ack_after, q_clear);
    vectors++; if (q_slave !== 1'b0) begin miscompares++; $display("FAIL mask_noclaim: got %b expected 0", q_slave); end
    reg_read(4'd4, r_data, r_dtack);
    vectors++; if (r_data !== 8'h00) begin miscompares++; $display("FAIL mask_read: got %h expected 00", r_data); end
    reg_write(4'd4, 8'h0F, 1'b0);
    vectors++; if (int_sig !== 1'b1) begin miscompares++; $display("FAIL mask_restore_int: got %b expected 1", int_sig); end
  endtask

  task automatic test_reset_abort();
    FCS_n = 1'b0; quickint_cycle = 1'b1; DOE = 1'b0; DS0_n = 1'b1;
    tick();
    vectors++; if (slave !== 1'b1) begin miscompares++; $display("FAIL abort_claim: got %b expected 1", slave); end
    IORST = 1'b1;
    tick();
    IORST = 1'b0;
    vectors++; if (slave !== 1'b0) begin miscompares++; $display("FAIL abort_slave: got %b expected 0", slave); end
    vectors++; if (dout !== 8'd26) begin miscompares++; $display("FAIL abort_dout: got %0d expected 26", dout); end
    DOE = 1'b1; DS0_n = 1'b0; SLAVE_n = 1'b0;
    tick(); tick();
    vectors++; if ({dtack, slave} !== 2'b00) begin miscompares++; $display("FAIL abort_no_dtack: got %b expected 00", {dtack, slave}); end
    bus_idle();
    tick();
    SINT_n = 4'b1110;
    tick(); tick();
    vectors++; if (int_sig !== 1'b1) begin miscompares++; $display("FAIL abort_passthru: got %b expected 1", int_sig); end
    qi_cycle(q_slave, q_dout, q_dtack, q_ack, q_ack_after, q_clear);
    vectors++; if (q_slave !== 1'b0) begin miscompares++; $display("FAIL abort_valid_cleared: got %b expected 0", q_slave); end
    reg_read(4'd0, r_data, r_dtack);
    vectors++; if (r_data !== 8'd26) begin miscompares++; $display("FAIL abort_vector_reset: got %0d expected 26", r_data); end
    reg_read(4'd5, r_data, r_dtack);
    vectors++; if (r_data !== 8'h00) begin miscompares++; $display("FAIL abort_mode_reset: got %h expected 00", r_data); end
    SINT_n = 4'hF;
    tick();
  endtask

  initial begin
    test_reset();
    test_passthrough();
    test_vector_delivery();
    test_priority();
    test_edge_mode();
    test_w1c_collision();
    test_enable_mask();
    test_reset_abort();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
